// File: rtl/alu_pkg.sv
// Shared ALU package.
// Holds the divider state encoding, the default datapath width, the
// divide-by-zero quotient constant and a helper for the iteration-counter width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  // Quotient reported when the divisor is zero.
  localparam logic [ALU_WIDTH-1:0] DIV_ZERO_Q = {ALU_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // Bits needed to count WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_i      current partial remainder (always < divisor_i)
//   dvd_bit_i  next dividend bit shifted into the remainder
//   divisor_i  divisor magnitude
//   rem_o      partial remainder after the trial subtraction
//   q_bit_o    quotient bit produced by this step
module alu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Shift, trial-subtract and restore.
  // Because rem_i < divisor_i, the shifted value is < 2*divisor_i, so a
  // WIDTH+1-bit difference has its top bit set exactly when a borrow occurred.
  always_comb begin
    shifted_s = {rem_i, dvd_bit_i};
    diff_s    = shifted_s - {1'b0, divisor_i};
    q_bit_o   = ~diff_s[WIDTH];
    if (q_bit_o) begin
      rem_o = diff_s[WIDTH-1:0];
    end else begin
      rem_o = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_div.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per clock.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   start        request a division (sampled only while idle)
//   A, B, Sign   dividend, divisor, signed select (sampled on the accept edge)
//   busy         operation in flight
//   done         one-cycle pulse: Q/R/flags just updated
//   Q, R         quotient / remainder, held until the next done
//   Z, N, V, DZ  zero, negative, signed overflow, divide-by-zero flags
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             DZ
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend in, quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;
  logic             dzf_q, dzf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .q_bit_o   (step_q_s)
  );

  // Operand magnitudes and sign fix-up of the finished quotient/remainder.
  // The most-negative dividend negates to itself, which is exactly the
  // unsigned magnitude needed, so overflow needs no special datapath.
  always_comb begin
    if (Sign && A[WIDTH-1]) begin
      a_mag_s = {WIDTH{1'b0}} - A;
    end else begin
      a_mag_s = A;
    end
    if (Sign && B[WIDTH-1]) begin
      b_mag_s = {WIDTH{1'b0}} - B;
    end else begin
      b_mag_s = B;
    end
    if (qneg_q) begin
      q_fix_s = {WIDTH{1'b0}} - dvd_q;
    end else begin
      q_fix_s = dvd_q;
    end
    if (rneg_q) begin
      r_fix_s = {WIDTH{1'b0}} - rem_q;
    end else begin
      r_fix_s = rem_q;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    z_d       = z_q;
    n_d       = n_q;
    v_d       = v_q;
    dzf_d     = dzf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          sign_d = Sign;
          qneg_d = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
          rneg_d = Sign & A[WIDTH-1];
          ovf_d  = Sign & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == {WIDTH{1'b1}});
          rem_d  = {WIDTH{1'b0}};
          dvs_d  = b_mag_s;
          cnt_d  = CW'(WIDTH - 1);
          if (B == {WIDTH{1'b0}}) begin
            // Keep the raw dividend: it becomes the remainder.
            dz_d    = 1'b1;
            dvd_d   = A;
            state_d = ST_FIX;
          end else begin
            dz_d    = 1'b0;
            dvd_d   = a_mag_s;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        rem_d = step_rem_s;
        dvd_d = {dvd_q[WIDTH-2:0], step_q_s};
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_FIX: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (dz_q) begin
          quo_out_d = {WIDTH{1'b1}};
          rem_out_d = dvd_q;
          z_d       = 1'b0;
          n_d       = sign_q;
          v_d       = 1'b0;
          dzf_d     = 1'b1;
        end else begin
          quo_out_d = q_fix_s;
          rem_out_d = r_fix_s;
          z_d       = (q_fix_s == {WIDTH{1'b0}});
          n_d       = sign_q & q_fix_s[WIDTH-1];
          v_d       = ovf_q;
          dzf_d     = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      dvd_q     <= {WIDTH{1'b0}};
      dvs_q     <= {WIDTH{1'b0}};
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      quo_out_q <= {WIDTH{1'b0}};
      rem_out_q <= {WIDTH{1'b0}};
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      dzf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      z_q       <= z_d;
      n_q       <= n_d;
      v_q       <= v_d;
      dzf_q     <= dzf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = quo_out_q;
  assign R    = rem_out_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign V    = v_q;
  assign DZ   = dzf_q;

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div (WIDTH=32): directed vector table,
// hand-written handshake/reset sequences and randomized operands checked
// against a plain-arithmetic reference model.
module tb_alu_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Sign;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] R;
  logic        Z;
  logic        N;
  logic        V;
  logic        DZ;

  int total;
  int bad;
  logic busy_gap;   // set when busy dropped while waiting for done
  logic busy_at_done;

  alu_div #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Sign  (Sign),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .Z     (Z),
    .N     (N),
    .V     (V),
    .DZ    (DZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        v;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: quotient truncates toward zero, remainder takes dividend's sign.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic z, output logic n, output logic v, output logic dz);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; v = 1'b0;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      q = qq[31:0]; r = rr[31:0]; dz = 1'b0;
      v = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end else begin
      q = a / b; r = a % b; dz = 1'b0; v = 1'b0;
    end
    z = (q == 32'd0);
    n = s & q[31];
  endtask

  // Issue one division (called just before a rising edge, start sampled there)
  // and return at the falling edge of the done cycle. lat = edge index of done.
  // ign_at > 0 raises a stray start with junk operands across that edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int ign_at, output int lat);
    A = a; B = b; Sign = s; start = 1'b1;
    busy_gap = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_gap = 1'b1;
      @(posedge clk); #1;
      lat++;
      if (ign_at > 0 && lat == ign_at - 1) begin
        start = 1'b1; A = 32'd7; B = 32'd7; Sign = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    busy_at_done = busy;
    if (lat >= 100) chk("done_timeout", 32'(lat), 32'd0);
  endtask

  task automatic chk_result(input string tag, input int lat, input vec_t e);
    chk({tag, "_latency"}, 32'(lat), e.dz ? 32'd1 : 32'd33);
    chk({tag, "_busy_during"}, {31'd0, busy_gap}, 32'd0);
    chk({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
    chk({tag, "_Q"}, Q, e.q);
    chk({tag, "_R"}, R, e.r);
    chk({tag, "_flags"}, {28'd0, Z, N, V, DZ}, {28'd0, e.z, e.n, e.v, e.dz});
  endtask

  vec_t vt[10];
  vec_t e;
  int   lat;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; A = 32'd0; B = 32'd0; Sign = 1'b0;
    busy_gap = 1'b0; busy_at_done = 1'b0;

    //        a             b             s     q             r             z     n     v     dz
    vt[0] = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1'b0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{32'h1234,     32'd0,        1'b1, 32'hFFFFFFFF, 32'h1234,     1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6] = '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{32'hFFFFFFF9, 32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    vt[8] = '{32'd5,        32'd10,       1'b0, 32'd0,        32'd5,        1'b1, 1'b0, 1'b0, 1'b0};
    vt[9] = '{32'h80000000, 32'd1,        1'b0, 32'h80000000, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {22'd0, busy, done, Z, N, V, DZ, 4'd0}, 32'd0);
    chk("reset_Q", Q, 32'd0);
    chk("reset_R", R, 32'd0);

    // Directed table (consecutive rows are issued back-to-back in the done cycle).
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].s, 0, lat);
      chk_result($sformatf("vec%0d", i), lat, vt[i]);
    end

    // Stray start at edge 5 ignored, then a start in the done cycle accepted.
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 5, lat);
    chk_result("ign_start", lat, '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    run_op(32'd0, 32'd3, 1'b0, 0, lat);
    chk_result("b2b", lat, '{32'd0, 32'd3, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});

    // Give Q/R non-zero contents, then reset in the middle of the next division.
    run_op(32'd100, 32'd7, 1'b0, 0, lat);
    A = 32'd1000; B = 32'd3; Sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_ctrl", {30'd0, busy, done}, 32'd0);
    chk("midreset_Q", Q, 32'd0);
    chk("midreset_R", R, 32'd0);
    chk("midreset_flags", {28'd0, Z, N, V, DZ}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) seen = 1'b1;
      end
      chk("no_done_after_reset", {31'd0, seen}, 32'd0);
    end
    run_op(32'd1000, 32'd3, 1'b0, 0, lat);
    chk_result("after_reset", lat, '{32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0});

    // Randomized operands with extra weight on the edge divisors.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      int          sel;
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFFFFFF;
        3:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      rs = 1'($urandom_range(0, 1));
      e.a = ra; e.b = rb; e.s = rs;
      model(ra, rb, rs, e.q, e.r, e.z, e.n, e.v, e.dz);
      run_op(ra, rb, rs, 0, lat);
      chk_result($sformatf("rnd%0d", i), lat, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_div.md
# alu_div

Iterative 32-bit integer divider for the DIV/DIVU instructions, placed beside the combinational SUB unit in the ALU. It consumes the same operand pair and `Sign` select from the operand mux. It produces quotient and remainder for the HI/LO write-back stage, plus SUB-style status flags. It is a restoring divider that resolves one quotient bit per clock, so it uses a start/busy/done handshake instead of a single-cycle result.

## Interface
- `WIDTH`, default 32: operand width. Must be a power of two and at least 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a division. Sampled only in IDLE.
- `A`  in  WIDTH  dividend. Sampled on the accept edge.
- `B`  in  WIDTH  divisor. Sampled on the accept edge.
- `Sign`  in  1  1 = two's-complement division (DIV), 0 = unsigned (DIVU). Sampled on the accept edge.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse marking a valid result.
- `Q`  out  WIDTH  quotient. Held until the next done.
- `R`  out  WIDTH  remainder. Held until the next done.
- `Z`  out  1  Q == 0.
- `N`  out  1  Q[WIDTH-1] when Sign=1; 0 when Sign=0.
- `V`  out  1  signed overflow (most-negative / -1).
- `DZ`  out  1  divide by zero.

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE, start=1, B≠0:**
  - Latch |A| and |B|. Magnitudes are used only when Sign=1; otherwise raw values.
  - Latch qneg = Sign & (A[msb]^B[msb]) and rneg = Sign & A[msb].
  - Clear the partial remainder. Set cnt = WIDTH-1. Go to RUN.
- **IDLE, start=1, B=0:** go to FIX with dz flag set. No iterations are run.
- **RUN, each edge:**
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from the WIDTH+1-bit shifted remainder.
  - If no borrow: keep the difference and set quotient bit 1. Otherwise keep the shifted remainder and set quotient bit 0.
  - After the step with cnt==0, go to FIX. Otherwise cnt decrements.
- **FIX, one edge:** register the results, pulse done, go to IDLE.
  - Normal case: Q = qneg ? -quo : quo and R = rneg ? -rem : rem.
  - Divide by zero: Q = all ones, R = A, DZ=1, V=0.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives Q=0x80000000, R=0, V=1. This falls out of the magnitude arithmetic; V is detected from the latched operands.
- **Flags:** Z, N, V and DZ update only in FIX, together with Q and R.
- **Ignored start:** start in RUN or FIX is ignored, with no queueing.
- **Reset:** asynchronous at any time. State becomes IDLE; Q, R, Z, N, V, DZ, busy and done all go to 0. An in-flight result is discarded.

## Timing
- **Accept:** start is accepted at edge 0 (state IDLE at that edge).
- **busy:** high from edge 0 until the edge that raises done.
- **Normal latency:** RUN occupies edges 1..WIDTH, FIX is edge WIDTH+1. done is high between edges WIDTH+1 and WIDTH+2 (edges 33–34 for WIDTH=32).
- **Divide-by-zero latency:** FIX is edge 1, so done is high between edges 1 and 2.
- **done:** exactly one cycle wide. busy is 0 in the done cycle.
- **Back-to-back:** start asserted in the done cycle is accepted, because state is IDLE.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Structure
- **Shared package `alu_pkg`:**
  - state encoding (IDLE=2'd0, RUN=2'd1, FIX=2'd2);
  - `ALU_WIDTH`=32;
  - `DIV_ZERO_Q` = all ones;
  - the counter width as $clog2(WIDTH).
- **Sub-module `alu_div_step`:**
  - Combinational single iteration.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem and quotient bit, using a WIDTH+1-bit subtraction.
  - Instantiated once; the FSM, counters and sign fix-up stay in `alu_div`.

## Test plan
- **Unsigned basic:** Sign=0, A=100, B=7, start pulse. Expect Q=14, R=2, Z=0, N=0, done exactly at edge 33, busy high edges 0–32.
- **Signed rounding toward zero:** Sign=1, A=0xFFFFFFF9 (-7), B=2. Expect Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1), N=1, V=0.
- **Signed overflow:** Sign=1, A=0x80000000, B=0xFFFFFFFF. Expect Q=0x80000000, R=0, V=1, N=1.
- **Divide by zero:** A=0x1234, B=0, either Sign. Expect done at edge 1, DZ=1, Q=0xFFFFFFFF, R=0x1234.
- **Back-to-back and ignored start:**
  - Sign=0, A=0xFFFFFFFF, B=1: expect Q=0xFFFFFFFF, R=0.
  - A start pulse at edge 5 is ignored.
  - A new start (A=0, B=3) in the done cycle is accepted and completes 34 cycles later with Q=0, Z=1.
- **Reset mid-operation:** assert reset asynchronously at cycle 10 of a division. Expect busy, done and all outputs at 0 immediately, no done pulse afterwards, and a fresh start after release completing normally.
